// File: rtl/rfsoc_config.sv
// Shared RFSoC control-plane constants: gpio_ctrl bit map, config register width, ADC capture FSM states.
package rfsoc_config;

    localparam int config_reg_width = 32;

    // gpio_ctrl bit map: serial data plus one shift clock per register
    localparam int sdata               = 0;
    localparam int adc_cycle_count_clk = 4;
    localparam int adc_pre_delay_clk   = 5;
    localparam int adc_decim_clk       = 6;

    localparam int decim_w = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        CAPT = 2'd2,
        DONE = 2'd3
    } adc_cap_state_t;

endpackage

// File: rtl/shift_register.sv
// LSB-first serial config register loaded from the PS gpio bus on rising edges of its shift clock bit.
module shift_register #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         shift_clk,
    input  logic         sdata,
    output logic [W-1:0] q
);

    logic shift_clk_d;

    // The shift clock is a slow PS-driven level, so it is edge-detected in the fabric clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_clk_d <= 1'b0;
            q           <= '0;
        end else begin
            shift_clk_d <= shift_clk;
            if (en && shift_clk && !shift_clk_d) begin
                q <= {sdata, q[W-1:1]};
            end
        end
    end

endmodule

// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl: on trigger waits a programmed pre-delay, then forwards a programmed number of ADC beats.
// Build macro ADC_CAPTURE_DECIM_EN adds the decim_factor register and beat decimation inside the window.
module adc_capture_ctrl
    import rfsoc_config::*;
#(
    parameter int DATA_W = 256,
    parameter int CFG_W  = config_reg_width
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    input  logic [15:0]       gpio_ctrl,
    input  logic              select_in,
    input  logic              trigger_in,
    output logic              busy,
    output logic              capture_done,
    output logic              overflow
);

    adc_cap_state_t state, state_next;

    logic [CFG_W-1:0] capture_cycles;
    logic [CFG_W-1:0] pre_delay_cycles;
    logic [CFG_W-1:0] cap_cnt;
    logic [CFG_W-1:0] pre_cnt;

    logic arm;
    logic in_capt;
    logic keep_beat;
    logic window_beat;
    logic done_set;
    logic gpio_unused;

    assign gpio_unused   = ^gpio_ctrl;
    assign s_axis_tready = 1'b1;

    shift_register #(.W(CFG_W)) u_cycle_count (
        .clk       (clk),
        .rst_n     (!rst),
        .en        (select_in),
        .shift_clk (gpio_ctrl[adc_cycle_count_clk]),
        .sdata     (gpio_ctrl[sdata]),
        .q         (capture_cycles)
    );

    shift_register #(.W(CFG_W)) u_pre_delay (
        .clk       (clk),
        .rst_n     (!rst),
        .en        (select_in),
        .shift_clk (gpio_ctrl[adc_pre_delay_clk]),
        .sdata     (gpio_ctrl[sdata]),
        .q         (pre_delay_cycles)
    );

`ifdef ADC_CAPTURE_DECIM_EN
    logic [decim_w-1:0] decim_factor;
    logic [decim_w-1:0] decim_cnt;

    shift_register #(.W(decim_w)) u_decim (
        .clk       (clk),
        .rst_n     (!rst),
        .en        (select_in),
        .shift_clk (gpio_ctrl[adc_decim_clk]),
        .sdata     (gpio_ctrl[sdata]),
        .q         (decim_factor)
    );

    // decim_cnt counts valid window beats modulo decim_factor; phase 0 is the kept beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            decim_cnt <= '0;
        end else if (arm) begin
            decim_cnt <= '0;
        end else if (in_capt && s_axis_tvalid) begin
            if (decim_factor <= decim_w'(1) || decim_cnt == decim_factor - decim_w'(1)) begin
                decim_cnt <= '0;
            end else begin
                decim_cnt <= decim_cnt + decim_w'(1);
            end
        end
    end

    assign keep_beat = (decim_cnt == '0);
`else
    assign keep_beat = 1'b1;
`endif

    assign window_beat = in_capt && s_axis_tvalid && keep_beat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (trigger_in) state_next = (capture_cycles == '0) ? DONE : PRE;
            PRE:  if (pre_cnt == '0) state_next = CAPT;
            CAPT: if (window_beat && cap_cnt <= CFG_W'(1)) state_next = DONE;
            DONE: if (!trigger_in) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        arm      = (state == IDLE) && trigger_in;
        in_capt  = (state == CAPT);
        done_set = (state_next == DONE) && (state != DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_cnt <= '0;
            pre_cnt <= '0;
        end else if (arm) begin
            cap_cnt <= capture_cycles;
            pre_cnt <= pre_delay_cycles;
        end else begin
            if (state == PRE && pre_cnt != '0) pre_cnt <= pre_cnt - CFG_W'(1);
            if (window_beat && cap_cnt != '0) cap_cnt <= cap_cnt - CFG_W'(1);
        end
    end

    // m_axis: a beat transfers on a clock edge where m_axis_tvalid and m_axis_tready are both 1;
    // while tvalid=1 and tready=0 the held tdata never changes, so a window beat arriving then is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            capture_done  <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            capture_done <= done_set;
            if (arm) overflow <= 1'b0;
            if (window_beat) begin
                if (m_axis_tvalid && !m_axis_tready) begin
                    overflow <= 1'b1;
                end else begin
                    m_axis_tdata  <= s_axis_tdata;
                    m_axis_tvalid <= 1'b1;
                end
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Self-checking bench for adc_capture_ctrl: randomized windows against a beat-level reference model.
module tb_adc_capture_ctrl;
    import rfsoc_config::*;

    localparam int DATA_W = 256;
    localparam int CFG_W  = config_reg_width;
    localparam int N      = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] s_axis_tdata;
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic [DATA_W-1:0] m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic [15:0]       gpio_ctrl;
    logic              select_in;
    logic              trigger_in;
    logic              busy;
    logic              capture_done;
    logic              overflow;

    int n_cmp;
    int n_err;

    // stimulus per interval i (driven after edge i, sampled by the DUT at edge i+1)
    bit trig_a[N];
    bit valid_a[N];
    bit ready_a[N];
    int vbase;

    // observations per interval and beats accepted by the FIFO
    bit                ob_valid[N];
    bit                ob_done[N];
    bit                ob_busy[N];
    bit                ob_over[N];
    logic [DATA_W-1:0] ob_data[N];
    logic [DATA_W-1:0] acc_q[$];

    // reference model results
    logic [DATA_W-1:0] exp_q[$];
    int                exp_done_i;
    int                exp_busy_lo;
    bit                exp_over;
    int                exp_t0;

    adc_capture_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .gpio_ctrl     (gpio_ctrl),
        .select_in     (select_in),
        .trigger_in    (trigger_in),
        .busy          (busy),
        .capture_done  (capture_done),
        .overflow      (overflow)
    );

    always #2 clk = ~clk;

    function automatic logic [DATA_W-1:0] beat(input int v);
        logic [DATA_W-1:0] r;
        for (int l = 0; l < 16; l++) r[l*16 +: 16] = 16'(v * 16 + l);
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic shift_reg(input int clk_bit, input logic [CFG_W-1:0] val, input int w, input bit sel);
        select_in = sel;
        for (int b = 0; b < w; b++) begin
            gpio_ctrl[sdata] = val[b];
            step();
            gpio_ctrl[clk_bit] = 1'b1;
            step();
            gpio_ctrl[clk_bit] = 1'b0;
            step();
        end
        select_in = 1'b0;
    endtask

    task automatic configure(input int p, input int c);
        shift_reg(adc_cycle_count_clk, CFG_W'(c), CFG_W, 1'b1);
        shift_reg(adc_pre_delay_clk, CFG_W'(p), CFG_W, 1'b1);
    endtask

    task automatic fill(input int t0, input int toff);
        vbase = $urandom_range(0, 4000);
        for (int i = 0; i < N; i++) begin
            trig_a[i]  = (t0 >= 0 && i >= t0 && i < toff);
            valid_a[i] = 1'b1;
            ready_a[i] = 1'b1;
        end
    endtask

    task automatic run_stim(input int n);
        acc_q.delete();
        for (int i = 0; i < n; i++) begin
            trigger_in    = trig_a[i];
            s_axis_tvalid = valid_a[i];
            m_axis_tready = ready_a[i];
            s_axis_tdata  = beat(vbase + i);
            ob_valid[i]   = m_axis_tvalid;
            ob_data[i]    = m_axis_tdata;
            ob_done[i]    = capture_done;
            ob_busy[i]    = busy;
            ob_over[i]    = overflow;
            if (m_axis_tvalid && ready_a[i]) acc_q.push_back(m_axis_tdata);
            step();
        end
    endtask

    // ---------------- reference model ----------------
    // Window = the first c kept valid ADC beats starting p+1 cycles after the cycle the trigger is sampled;
    // a one-deep output slot either hands its beat to the FIFO or, if stuck, makes the new beat drop.
    task automatic model_run(input int n, input int p, input int c, input int decim);
        int                kept;
        int                vidx;
        bit                v;
        bit                xfer;
        bit                win;
        logic [DATA_W-1:0] slot;
        kept = 0; vidx = 0; v = 1'b0; slot = '0;
        exp_q.delete();
        exp_done_i = -1; exp_busy_lo = -1; exp_over = 1'b0; exp_t0 = -1;
        for (int i = 0; i < n; i++) if (trig_a[i]) begin exp_t0 = i; break; end
        for (int i = 0; i < n; i++) begin
            xfer = v && ready_a[i];
            win  = 1'b0;
            if (xfer) exp_q.push_back(slot);
            if (exp_t0 >= 0 && c > 0 && i >= exp_t0 + p + 2 && kept < c && valid_a[i]) begin
                if (decim <= 1 || vidx % decim == 0) begin
                    win = 1'b1;
                    kept++;
                    if (kept == c) exp_done_i = i + 1;
                end
                vidx++;
            end
            if (win) begin
                if (v && !ready_a[i]) exp_over = 1'b1;
                else begin slot = beat(vbase + i); v = 1'b1; end
            end else if (xfer) begin
                v = 1'b0;
            end
        end
        if (c == 0 && exp_t0 >= 0) exp_done_i = exp_t0 + 1;
        if (exp_done_i >= 0)
            for (int j = exp_done_i; j < n; j++) if (!trig_a[j]) begin exp_busy_lo = j + 1; break; end
    endtask

    function automatic int count_done(input int n);
        int k = 0;
        for (int i = 0; i < n; i++) if (ob_done[i]) k++;
        return k;
    endfunction

    function automatic int first_done(input int n);
        for (int i = 0; i < n; i++) if (ob_done[i]) return i;
        return -1;
    endfunction

    function automatic int first_valid(input int n);
        for (int i = 0; i < n; i++) if (ob_valid[i]) return i;
        return -1;
    endfunction

    function automatic int busy_errs(input int n);
        int  k = 0;
        bit  e;
        for (int i = 0; i < n; i++) begin
            e = (exp_t0 >= 0 && i >= exp_t0 + 1 && (exp_busy_lo < 0 || i < exp_busy_lo));
            if (ob_busy[i] != e) k++;
        end
        return k;
    endfunction

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        repeat (3) step();
        n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid: got %0b expected 0", m_axis_tvalid); end
        n_cmp++; if (m_axis_tdata !== '0) begin n_err++; $display("FAIL reset_tdata: got %0h expected 0", m_axis_tdata); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        n_cmp++; if (capture_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %0b expected 0", capture_done); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %0b expected 0", overflow); end
        n_cmp++; if (s_axis_tready !== 1'b1) begin n_err++; $display("FAIL s_tready: got %0b expected 1", s_axis_tready); end
        rst = 1'b0;
        step();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %0b expected 0", busy); end
    endtask

    task automatic test_basic();
        configure(0, 4);
        fill(2, 10);
        run_stim(20);
        model_run(20, 0, 4, 1);
        n_cmp++; if (acc_q.size() != 4) begin n_err++; $display("FAIL basic_count: got %0d expected 4", acc_q.size()); end
        for (int k = 0; k < acc_q.size() && k < 4; k++) begin
            n_cmp++; if (acc_q[k] !== beat(vbase + 4 + k)) begin n_err++; $display("FAIL basic_beat%0d: got %0h expected %0h", k, acc_q[k], beat(vbase + 4 + k)); end
        end
        n_cmp++; if (first_valid(20) != 5) begin n_err++; $display("FAIL basic_latency: got %0d expected 5", first_valid(20)); end
        n_cmp++; if (count_done(20) != 1) begin n_err++; $display("FAIL basic_done_cnt: got %0d expected 1", count_done(20)); end
        n_cmp++; if (first_done(20) != exp_done_i) begin n_err++; $display("FAIL basic_done_at: got %0d expected %0d", first_done(20), exp_done_i); end
        n_cmp++; if (ob_over[19] !== 1'b0) begin n_err++; $display("FAIL basic_overflow: got %0b expected 0", ob_over[19]); end
        n_cmp++; if (busy_errs(20) != 0) begin n_err++; $display("FAIL basic_busy: got %0d bad cycles expected 0", busy_errs(20)); end
    endtask

    task automatic test_pre_delay();
        configure(3, 2);
        fill(2, 14);
        run_stim(24);
        model_run(24, 3, 2, 1);
        n_cmp++; if (acc_q.size() != exp_q.size()) begin n_err++; $display("FAIL pre_count: got %0d expected %0d", acc_q.size(), exp_q.size()); end
        n_cmp++; if (acc_q.size() == 0 || acc_q[0] !== beat(vbase + 7)) begin n_err++; $display("FAIL pre_first_beat: got %0h expected %0h", (acc_q.size() > 0) ? acc_q[0] : '0, beat(vbase + 7)); end
        for (int k = 0; k < acc_q.size() && k < exp_q.size(); k++) begin
            n_cmp++; if (acc_q[k] !== exp_q[k]) begin n_err++; $display("FAIL pre_beat%0d: got %0h expected %0h", k, acc_q[k], exp_q[k]); end
        end
        n_cmp++; if (ob_busy[14] !== 1'b1 || ob_busy[15] !== 1'b0) begin n_err++; $display("FAIL pre_busy_drop: got %0b%0b expected 10", ob_busy[14], ob_busy[15]); end
        n_cmp++; if (busy_errs(24) != 0) begin n_err++; $display("FAIL pre_busy: got %0d bad cycles expected 0", busy_errs(24)); end
    endtask

    task automatic test_backpressure();
        configure(1, 4);
        fill(2, 12);
        ready_a[6] = 1'b0;
        ready_a[7] = 1'b0;
        run_stim(24);
        model_run(24, 1, 4, 1);
        n_cmp++; if (acc_q.size() != 2) begin n_err++; $display("FAIL bp_count: got %0d expected 2", acc_q.size()); end
        for (int k = 0; k < acc_q.size() && k < exp_q.size(); k++) begin
            n_cmp++; if (acc_q[k] !== exp_q[k]) begin n_err++; $display("FAIL bp_beat%0d: got %0h expected %0h", k, acc_q[k], exp_q[k]); end
        end
        n_cmp++; if (ob_data[7] !== beat(vbase + 5) || ob_data[8] !== beat(vbase + 5)) begin n_err++; $display("FAIL bp_hold: got %0h expected %0h", ob_data[8], beat(vbase + 5)); end
        n_cmp++; if (ob_over[23] !== 1'b1) begin n_err++; $display("FAIL bp_overflow: got %0b expected 1", ob_over[23]); end
        fill(2, 10);
        run_stim(20);
        n_cmp++; if (ob_over[2] !== 1'b1) begin n_err++; $display("FAIL bp_sticky: got %0b expected 1", ob_over[2]); end
        n_cmp++; if (ob_over[3] !== 1'b0 || ob_over[19] !== 1'b0) begin n_err++; $display("FAIL bp_clear: got %0b%0b expected 00", ob_over[3], ob_over[19]); end
    endtask

    task automatic test_zero_count();
        configure(2, 0);
        fill(2, N);
        run_stim(16);
        n_cmp++; if (first_valid(16) != -1) begin n_err++; $display("FAIL zero_tvalid: got %0d expected -1", first_valid(16)); end
        n_cmp++; if (count_done(16) != 1) begin n_err++; $display("FAIL zero_done_cnt: got %0d expected 1", count_done(16)); end
        n_cmp++; if (first_done(16) != 3) begin n_err++; $display("FAIL zero_done_at: got %0d expected 3", first_done(16)); end
        n_cmp++; if (ob_busy[15] !== 1'b1) begin n_err++; $display("FAIL zero_hold_done: got %0b expected 1", ob_busy[15]); end
        fill(-1, 0);
        run_stim(4);
        n_cmp++; if (ob_busy[0] !== 1'b1 || ob_busy[1] !== 1'b0) begin n_err++; $display("FAIL zero_release: got %0b%0b expected 10", ob_busy[0], ob_busy[1]); end
        n_cmp++; if (count_done(4) != 0) begin n_err++; $display("FAIL zero_no_retrig: got %0d expected 0", count_done(4)); end
    endtask

    task automatic test_random();
        int p, c, t0;
        for (int it = 0; it < 6; it++) begin
            p  = $urandom_range(0, 5);
            c  = $urandom_range(1, 6);
            t0 = $urandom_range(1, 4);
            configure(p, c);
            fill(t0, t0 + $urandom_range(1, 40));
            for (int i = 0; i < 24; i++) valid_a[i] = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 32; i++) ready_a[i] = ($urandom_range(0, 2) != 0);
            run_stim(48);
            model_run(48, p, c, 1);
            n_cmp++; if (acc_q.size() != exp_q.size()) begin n_err++; $display("FAIL rand%0d_count: got %0d expected %0d", it, acc_q.size(), exp_q.size()); end
            for (int k = 0; k < acc_q.size() && k < exp_q.size(); k++) begin
                n_cmp++; if (acc_q[k] !== exp_q[k]) begin n_err++; $display("FAIL rand%0d_beat%0d: got %0h expected %0h", it, k, acc_q[k], exp_q[k]); end
            end
            n_cmp++; if (count_done(48) != 1 || first_done(48) != exp_done_i) begin n_err++; $display("FAIL rand%0d_done: got %0d expected %0d", it, first_done(48), exp_done_i); end
            n_cmp++; if (ob_over[47] !== exp_over) begin n_err++; $display("FAIL rand%0d_overflow: got %0b expected %0b", it, ob_over[47], exp_over); end
            n_cmp++; if (busy_errs(48) != 0) begin n_err++; $display("FAIL rand%0d_busy: got %0d bad cycles expected 0", it, busy_errs(48)); end
        end
    endtask

`ifdef ADC_CAPTURE_DECIM_EN
    task automatic test_decim();
        configure(0, 3);
        shift_reg(adc_decim_clk, CFG_W'(3), decim_w, 1'b1);
        fill(2, 20);
        run_stim(30);
        model_run(30, 0, 3, 3);
        n_cmp++; if (acc_q.size() != 3) begin n_err++; $display("FAIL decim_count: got %0d expected 3", acc_q.size()); end
        for (int k = 0; k < acc_q.size() && k < 3; k++) begin
            n_cmp++; if (acc_q[k] !== beat(vbase + 4 + 3 * k)) begin n_err++; $display("FAIL decim_beat%0d: got %0h expected %0h", k, acc_q[k], beat(vbase + 4 + 3 * k)); end
        end
        n_cmp++; if (first_done(30) != exp_done_i) begin n_err++; $display("FAIL decim_done: got %0d expected %0d", first_done(30), exp_done_i); end
        shift_reg(adc_decim_clk, CFG_W'(1), decim_w, 1'b1);
    endtask
`endif

    task automatic test_async_reset();
        configure(2, 6);
        fill(2, 14);
        run_stim(8);
        n_cmp++; if (ob_valid[7] !== 1'b1) begin n_err++; $display("FAIL ar_pre_capt: got %0b expected 1", ob_valid[7]); end
        rst = 1'b1;
        #1;
        n_cmp++; if ({m_axis_tvalid, busy, overflow, capture_done} !== 4'b0) begin n_err++; $display("FAIL ar_flags: got %b expected 0000", {m_axis_tvalid, busy, overflow, capture_done}); end
        n_cmp++; if (m_axis_tdata !== '0) begin n_err++; $display("FAIL ar_tdata: got %0h expected 0", m_axis_tdata); end
        trigger_in = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        fill(1, 4);
        run_stim(10);
        n_cmp++; if (first_valid(10) != -1 || count_done(10) != 1 || first_done(10) != 2) begin n_err++; $display("FAIL ar_cfg_cleared: got valid@%0d done@%0d expected -1 2", first_valid(10), first_done(10)); end
        configure(0, 5);
        shift_reg(adc_cycle_count_clk, CFG_W'(2), CFG_W, 1'b0);
        fill(2, 12);
        run_stim(24);
        model_run(24, 0, 5, 1);
        n_cmp++; if (acc_q.size() != 5) begin n_err++; $display("FAIL sel_count: got %0d expected 5", acc_q.size()); end
        for (int k = 0; k < acc_q.size() && k < exp_q.size(); k++) begin
            n_cmp++; if (acc_q[k] !== exp_q[k]) begin n_err++; $display("FAIL sel_beat%0d: got %0h expected %0h", k, acc_q[k], exp_q[k]); end
        end
    endtask

    initial begin
        rst           = 1'b1;
        gpio_ctrl     = '0;
        select_in     = 1'b0;
        trigger_in    = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b1;
        n_cmp         = 0;
        n_err         = 0;
        test_reset();
        test_basic();
        test_pre_delay();
        test_backpressure();
        test_zero_count();
        test_random();
`ifdef ADC_CAPTURE_DECIM_EN
        test_decim();
`endif
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
